// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the core's single memory port between the instruction fetch unit
//   (IFU, read-only) and the load/store unit (LSU, read/write). Only one
//   transaction is in flight at a time. Ties go round-robin, or always to the
//   LSU when LSU_PRIO = 1.
//
//   Handshakes: a transfer happens on any channel in the cycle where both
//   valid and ready are high at the rising clock edge. The side that raises
//   valid holds it, with its payload unchanged, until ready is seen.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ifu_req_*         IFU request channel (valid/ready/addr)
//   ifu_rsp_*         IFU response channel (valid/ready/rdata/err)
//   lsu_req_*         LSU request channel (valid/ready/addr/wen/wdata/wstrb)
//   lsu_rsp_*         LSU response channel (valid/ready/rdata/err)
//   mem_req_*         request to memory, driven from registers
//   mem_rsp_*         response from memory
//   busy              transaction in flight (FSM not in IDLE)
//   owner             current/last grant: 0 = IFU, 1 = LSU
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LSU_PRIO   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_WIDTH-1:0] ifu_rsp_rdata,
    output logic                  ifu_rsp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    input  logic [STRB_WIDTH-1:0] lsu_req_wstrb,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_WIDTH-1:0] lsu_rsp_rdata,
    output logic                  lsu_rsp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [STRB_WIDTH-1:0] mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    input  logic                  mem_rsp_err,

    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    // r_owner doubles as last_grant: it is only rewritten on a new grant.
    logic                  r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;

    logic                  w_lsu_prio;
    logic                  w_grant_lsu;
    logic                  w_grant_ifu;
    logic                  w_hs_ifu;
    logic                  w_hs_lsu;

    assign w_lsu_prio = (LSU_PRIO != 0);

    // LSU wins when alone, when it has fixed priority, or when the IFU had
    // the previous grant. The IFU takes whatever the LSU does not.
    assign w_grant_lsu = lsu_req_valid & (~ifu_req_valid | w_lsu_prio | ~r_owner);
    assign w_grant_ifu = ifu_req_valid & ~w_grant_lsu;

    assign w_hs_ifu = ifu_req_valid & ifu_req_ready;
    assign w_hs_lsu = lsu_req_valid & lsu_req_ready;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and channel outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_rdata = '0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_rdata = '0;
        lsu_rsp_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                ifu_req_ready = w_grant_ifu;
                lsu_req_ready = w_grant_lsu;
                if (w_hs_ifu || w_hs_lsu) begin
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = S_RESP;
                end
            end

            S_RESP: begin
                // Unbuffered passthrough: the owner's rsp_ready stalls memory.
                if (r_owner) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rsp_rdata = mem_rsp_rdata;
                    lsu_rsp_err   = mem_rsp_err;
                    mem_rsp_ready = lsu_rsp_ready;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rsp_rdata = mem_rsp_rdata;
                    ifu_rsp_err   = mem_rsp_err;
                    mem_rsp_ready = ifu_rsp_ready;
                end
                if (mem_rsp_valid && mem_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Request registers and owner. Captured only on a grant handshake, so
    // the memory request stays stable through any mem_req_ready stall.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 1'b1;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_hs_lsu) begin
            r_owner <= 1'b1;
            r_addr  <= lsu_req_addr;
            r_wen   <= lsu_req_wen;
            r_wdata <= lsu_req_wdata;
            r_wstrb <= lsu_req_wstrb;
        end else if (w_hs_ifu) begin
            r_owner <= 1'b0;
            r_addr  <= ifu_req_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end
    end

    assign mem_req_addr  = r_addr;
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wstrb = r_wstrb;
    assign busy          = (r_state != S_IDLE);
    assign owner         = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. u_dut runs round-robin with a bench-
//   controlled memory; u_prio runs with LSU_PRIO = 1 against a zero-wait
//   memory tied off in the bench. Inputs change on the falling edge and
//   outputs are sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- round-robin DUT signals ----------------
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_req_addr;
  logic          ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata;
  logic [SW-1:0] lsu_req_wstrb;
  logic          lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [DW-1:0] lsu_rsp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [SW-1:0] mem_req_wstrb;
  logic          mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [DW-1:0] mem_rsp_rdata;
  logic          busy, owner;

  // ---------------- LSU-priority DUT signals ----------------
  logic          p_ifu_valid, p_ifu_ready, p_lsu_valid, p_lsu_ready;
  logic          p_ifu_rsp_valid, p_ifu_rsp_err, p_lsu_rsp_valid, p_lsu_rsp_err;
  logic [DW-1:0] p_ifu_rsp_rdata, p_lsu_rsp_rdata;
  logic          p_mem_req_valid, p_mem_req_wen, p_mem_rsp_ready;
  logic [AW-1:0] p_mem_req_addr;
  logic [DW-1:0] p_mem_req_wdata;
  logic [SW-1:0] p_mem_req_wstrb;
  logic          p_busy, p_owner;
  logic          one = 1'b1;
  logic          zero = 1'b0;
  logic [AW-1:0] p_ifu_addr = 32'h0000_1000;
  logic [AW-1:0] p_lsu_addr = 32'h0000_2000;
  logic [DW-1:0] p_wdata = 32'h0;
  logic [SW-1:0] p_wstrb = 4'h0;
  logic [DW-1:0] p_rdata = 32'h0000_0042;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .LSU_PRIO(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .busy(busy), .owner(owner)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .LSU_PRIO(1)) u_prio (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(p_ifu_valid), .ifu_req_ready(p_ifu_ready), .ifu_req_addr(p_ifu_addr),
    .ifu_rsp_valid(p_ifu_rsp_valid), .ifu_rsp_ready(one),
    .ifu_rsp_rdata(p_ifu_rsp_rdata), .ifu_rsp_err(p_ifu_rsp_err),
    .lsu_req_valid(p_lsu_valid), .lsu_req_ready(p_lsu_ready), .lsu_req_addr(p_lsu_addr),
    .lsu_req_wen(zero), .lsu_req_wdata(p_wdata), .lsu_req_wstrb(p_wstrb),
    .lsu_rsp_valid(p_lsu_rsp_valid), .lsu_rsp_ready(one),
    .lsu_rsp_rdata(p_lsu_rsp_rdata), .lsu_rsp_err(p_lsu_rsp_err),
    .mem_req_valid(p_mem_req_valid), .mem_req_ready(one), .mem_req_addr(p_mem_req_addr),
    .mem_req_wen(p_mem_req_wen), .mem_req_wdata(p_mem_req_wdata), .mem_req_wstrb(p_mem_req_wstrb),
    .mem_rsp_valid(one), .mem_rsp_ready(p_mem_rsp_ready),
    .mem_rsp_rdata(p_rdata), .mem_rsp_err(zero),
    .busy(p_busy), .owner(p_owner)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];   // expected grant order (0 = IFU, 1 = LSU)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wstrb = '0; lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0413; mem_rsp_err = 1'b0;
    p_ifu_valid = 1'b0; p_lsu_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int n_grants, last_cyc, p_lsu_cnt, p_ifu_cnt;
  logic seen;

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
    chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
    rst_n = 1'b1;

    // ---- IFU-only read, zero-wait memory ----
    step(); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; #1;
    chk("t1_c0_ifu_ready", ifu_req_ready, 1);
    chk("t1_c0_lsu_ready", lsu_req_ready, 0);
    step(); ifu_req_valid = 1'b0; #1;
    chk("t1_c1_mem_valid", mem_req_valid, 1);
    chk("t1_c1_mem_addr", mem_req_addr, 32'h8000_0000);
    chk("t1_c1_mem_wen", mem_req_wen, 0);
    chk("t1_c1_mem_wstrb", mem_req_wstrb, 0);
    chk("t1_c1_rsp_ignored", mem_rsp_ready, 0);
    chk("t1_c1_ifu_rsp_valid", ifu_rsp_valid, 0);
    step(); #1;
    chk("t1_c2_ifu_rsp_valid", ifu_rsp_valid, 1);
    chk("t1_c2_ifu_rdata", ifu_rsp_rdata, 32'h0000_0413);
    chk("t1_c2_mem_rsp_ready", mem_rsp_ready, 1);
    chk("t1_c2_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk("t1_c2_busy", busy, 1);
    step(); #1;
    chk("t1_c3_busy", busy, 0);
    chk("t1_c3_owner", owner, 0);

    // ---- both masters continuously valid, round-robin ----
    do_reset();
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    n_grants = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      if (cyc == 0) begin
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0200;
      end
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        chk("t2_one_hot", ifu_req_ready & lsu_req_ready, 0);
        if (exp_q.size() == 0) chk("t2_extra_grant", 1, 0);
        else chk("t2_grant_order", lsu_req_ready, exp_q.pop_front());
        if (n_grants > 0) chk("t2_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        n_grants++;
      end else if (!busy) begin
        chk("t2_idle_without_grant", busy, 1);
      end
    end
    chk("t2_grant_count", n_grants, 4);
    step(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // ---- LSU_PRIO = 1: LSU wins every tie ----
    do_reset();
    p_lsu_cnt = 0; p_ifu_cnt = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      step();
      if (cyc == 0) begin p_ifu_valid = 1'b1; p_lsu_valid = 1'b1; end
      #1;
      if (p_lsu_ready) p_lsu_cnt++;
      if (p_ifu_ready) p_ifu_cnt++;
    end
    chk("t3_lsu_grants", p_lsu_cnt, 6);
    chk("t3_ifu_grants", p_ifu_cnt, 0);
    step(); p_lsu_valid = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
      #1;
      if (p_ifu_ready) seen = 1'b1;
      else step();
    end
    chk("t3_ifu_after_lsu_drops", seen, 1);
    p_ifu_valid = 1'b0;
    repeat (4) step();

    // ---- LSU store with 4 cycles of mem_req_ready low ----
    do_reset();
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0010; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'h3; #1;
    chk("t4_lsu_ready", lsu_req_ready, 1);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      step();
      lsu_req_valid = 1'b0; lsu_req_addr = $urandom_range(0, 255);
      lsu_req_wdata = $urandom_range(0, 65535); lsu_req_wstrb = 4'hC; lsu_req_wen = 1'b0;
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0300; #1;
      chk("t4_stall_valid", mem_req_valid, 1);
      chk("t4_stall_addr", mem_req_addr, 32'h8000_0010);
      chk("t4_stall_wen", mem_req_wen, 1);
      chk("t4_stall_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      chk("t4_stall_wstrb", mem_req_wstrb, 4'h3);
      chk("t4_stall_ifu_ready", ifu_req_ready, 0);
      chk("t4_stall_lsu_rsp", lsu_rsp_valid, 0);
    end
    step(); mem_req_ready = 1'b1; #1;
    chk("t4_c5_mem_valid", mem_req_valid, 1);
    chk("t4_c5_ifu_ready", ifu_req_ready, 0);
    step(); #1;
    chk("t4_c6_no_rsp_yet", lsu_rsp_valid, 0);
    chk("t4_c6_ifu_ready", ifu_req_ready, 0);
    chk("t4_c6_busy", busy, 1);
    step(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_1234; #1;
    chk("t4_c7_lsu_rsp_valid", lsu_rsp_valid, 1);
    chk("t4_c7_ifu_rsp_valid", ifu_rsp_valid, 0);
    chk("t4_c7_mem_rsp_ready", mem_rsp_ready, 1);
    chk("t4_c7_ifu_ready", ifu_req_ready, 0);
    step(); #1;
    chk("t4_c8_ifu_ready", ifu_req_ready, 1);
    ifu_req_valid = 1'b0;

    // ---- LSU response backpressure ----
    step();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0020; lsu_req_wen = 1'b0;
    lsu_rsp_ready = 1'b0; mem_rsp_rdata = 32'h0000_5678; #1;
    chk("t5_lsu_ready", lsu_req_ready, 1);
    step(); lsu_req_valid = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      step(); #1;
      chk("t5_bp_lsu_rsp_valid", lsu_rsp_valid, 1);
      chk("t5_bp_mem_rsp_ready", mem_rsp_ready, 0);
      chk("t5_bp_busy", busy, 1);
    end
    step(); lsu_rsp_ready = 1'b1; #1;
    chk("t5_release_mem_rsp_ready", mem_rsp_ready, 1);
    chk("t5_release_rdata", lsu_rsp_rdata, 32'h0000_5678);
    step(); #1;
    chk("t5_done_busy", busy, 0);
    chk("t5_done_owner", owner, 1);

    // ---- abort during REQ, stray response, error response ----
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040; mem_req_ready = 1'b0; #1;
    chk("t6_ifu_ready", ifu_req_ready, 1);
    step(); ifu_req_valid = 1'b0; #1;
    chk("t6_req_valid", mem_req_valid, 1);
    chk("t6_req_owner", owner, 0);
    rst_n = 1'b0; #1;
    chk("t6_abort_valid", mem_req_valid, 0);
    chk("t6_abort_owner", owner, 1);
    chk("t6_abort_busy", busy, 0);
    step(); rst_n = 1'b1; mem_rsp_valid = 1'b1; #1;
    chk("t6_stray_mem_rsp_ready", mem_rsp_ready, 0);
    chk("t6_stray_ifu_rsp", ifu_rsp_valid, 0);
    chk("t6_stray_lsu_rsp", lsu_rsp_valid, 0);
    step();
    mem_req_ready = 1'b1; mem_rsp_err = 1'b1; mem_rsp_rdata = 32'h0000_0413;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0044; #1;
    chk("t6_err_ifu_ready", ifu_req_ready, 1);
    step(); ifu_req_valid = 1'b0;
    step(); #1;
    chk("t6_err_rsp_valid", ifu_rsp_valid, 1);
    chk("t6_err_flag", ifu_rsp_err, 1);
    chk("t6_err_lsu_flag", lsu_rsp_err, 0);
    step(); #1;
    chk("t6_err_idle", busy, 0);
    mem_rsp_err = 1'b0;

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
